segmented_adder_seq: RTL and testbench
======================================

SEGMENTED_ADDER_SEQ -- requirements
Module: segmented_adder_seq

Interface
REQ-001 SHALL have parameter D_WIDTH, default 16, giving the segment width in bits (>=1).
REQ-002 SHALL have parameter N_SEG, default 4, giving the number of segments per operand (>=1); operand width W = D_WIDTH*N_SEG.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports in_a_i and in_b_i, input, W bits each: the operands.
REQ-006 SHALL have port in_c_i, input, 1 bit: the carry-in.
REQ-007 SHALL have port in_valid_i, input, 1 bit, and port in_ready_o, output, 1 bit: the input handshake.
REQ-008 SHALL have port out_s_o, output, W bits: the registered sum.
REQ-009 SHALL have port out_c_o, output, 1 bit: the registered carry-out.
REQ-010 SHALL have port out_valid_o, output, 1 bit, and port out_ready_i, input, 1 bit: the output handshake.
REQ-011 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL compute {out_c_o, out_s_o} = in_a_i + in_b_i + in_c_i over W bits, using exactly one D_WIDTH-bit carry-lookahead adder instance time-shared across segments.
REQ-013 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-014 SHALL set in_ready_o = 1 only in IDLE.
REQ-015 SHALL accept an input on a cycle with in_valid_i & in_ready_o, latching operands and carry-in into internal registers, clearing the segment counter and the result register, and moving to CALC.
REQ-016 SHALL, in CALC, add segment k (bits k*D_WIDTH +: D_WIDTH, k from 0 up to N_SEG-1, LSB first) with the stored carry, write the segment sum into result bits k, and register the segment carry as the next carry-in.
REQ-017 SHALL use a segment counter of width max(1, clog2(N_SEG)) from math_pkg, incrementing once per CALC cycle, and transition CALC->DONE when the counter equals N_SEG-1.
REQ-018 SHALL assert out_valid_o exactly N_SEG cycles after the accepting cycle, i.e. in the first DONE cycle, with out_c_o equal to the carry of the final segment.
REQ-019 SHALL hold out_valid_o, out_s_o and out_c_o stable in DONE until out_valid_o & out_ready_i, then go to IDLE on the next edge; throughput SHALL be one operation per N_SEG+2 cycles with out_ready_i held high.
REQ-020 SHALL ignore in_valid_i and all input data outside IDLE; operands changing during CALC SHALL NOT affect the result.
REQ-021 SHALL handle N_SEG=1 with a single CALC cycle.
REQ-022 SHALL keep out_s_o and out_c_o holding the last completed result in IDLE, and SHALL keep out_valid_o low in IDLE.

Reset
REQ-023 SHALL, on rst_n_i low and independent of clk_i, force state IDLE, segment counter 0, carry register 0, out_s_o 0, out_c_o 0, out_valid_o 0, busy_o 0, and in_ready_o 1 after release.
REQ-024 SHALL abort any operation in progress on reset in CALC or DONE, with no output handshake afterward.

Configuration
REQ-025 SHALL, with macro SEGMENTED_ADDER_SEQ_SUB_EN defined, add input port sub_i (1 bit, sampled at accept), compute in_a_i + ~in_b_i + 1 when sub_i = 1 (in_c_i ignored), and compute as in REQ-012 when sub_i = 0; out_c_o SHALL then be the not-borrow.
REQ-026 SHALL, without SEGMENTED_ADDER_SEQ_SUB_EN, omit port sub_i and all subtraction logic, and always perform addition.

Verification
REQ-027 SHALL cover carry propagation across all segments: D_WIDTH=16, N_SEG=4, a=0xFFFF_FFFF_FFFF_FFFF, b=0, c_i=1 -> out_s_o=0, out_c_o=1, out_valid_o high 4 cycles after accept.
REQ-028 SHALL cover carry across one segment boundary: a=0x0000_0000_0000_FFFF, b=0x1, c_i=0 -> out_s_o=0x0000_0000_0001_0000, out_c_o=0.
REQ-029 SHALL cover back-pressure: out_ready_i=0 for 10 cycles in DONE -> out_valid_o and data held stable, in_ready_o=0, a second in_valid_i pulse is ignored; out_ready_i=1 -> IDLE next cycle.
REQ-030 SHALL cover reset mid-operation: rst_n_i low during CALC segment 2 -> all outputs 0, IDLE; a new op 3+4 afterward -> out_s_o=7.
REQ-031 SHALL cover subtraction with SEGMENTED_ADDER_SEQ_SUB_EN: sub_i=1, a=5, b=7 -> out_s_o=0xFFFF_FFFF_FFFF_FFFE, out_c_o=0; a=7, b=5 -> out_s_o=2, out_c_o=1.
REQ-032 SHALL cover input isolation: a and b changed every cycle during CALC -> result equals the sum of the values latched at accept.

Source files
------------

// File: rtl/segmented_adder_seq.sv
// Sequential W-bit adder: one D_WIDTH-bit CLA reused for N_SEG segments, LSB first.
// Ports: clk_i, rst_n_i, in_a_i/in_b_i/in_c_i + in_valid_i/in_ready_o, out_s_o/out_c_o + out_valid_o/out_ready_i, busy_o.
// Option: define SEGMENTED_ADDER_SEQ_SUB_EN to add sub_i (a - b when high; out_c_o is then not-borrow).
package math_pkg;
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

module segmented_adder_seq_cla #(
  parameter int D_WIDTH = 16
) (
  input  logic [D_WIDTH-1:0] a,
  input  logic [D_WIDTH-1:0] b,
  input  logic               ci,
  output logic [D_WIDTH-1:0] s,
  output logic               co
);
  logic [D_WIDTH-1:0] g;
  logic [D_WIDTH-1:0] p;
  logic [D_WIDTH:0]   cy;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of generate/propagate products.
  always_comb begin
    logic term;
    logic prod;
    cy    = '0;
    cy[0] = ci;
    term  = 1'b0;
    prod  = 1'b0;
    for (int i = 0; i < D_WIDTH; i++) begin
      prod = ci;
      for (int k = 0; k <= i; k++) prod = prod & p[k];
      term = prod;
      for (int j = 0; j <= i; j++) begin
        prod = g[j];
        for (int k = j + 1; k <= i; k++) prod = prod & p[k];
        term = term | prod;
      end
      cy[i+1] = term;
    end
  end

  assign s  = p ^ cy[D_WIDTH-1:0];
  assign co = cy[D_WIDTH];
endmodule

module segmented_adder_seq
  import math_pkg::*;
#(
  parameter int D_WIDTH = 16,
  parameter int N_SEG   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [D_WIDTH*N_SEG-1:0] in_a_i,
  input  logic [D_WIDTH*N_SEG-1:0] in_b_i,
  input  logic                     in_c_i,
`ifdef SEGMENTED_ADDER_SEQ_SUB_EN
  input  logic                     sub_i,
`endif
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [D_WIDTH*N_SEG-1:0] out_s_o,
  output logic                     out_c_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     busy_o
);
  localparam int W  = D_WIDTH * N_SEG;
  localparam int CW = clog2_min1(N_SEG);
  localparam logic [CW-1:0] LAST = CW'(N_SEG - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic              cy_q;
  logic [CW-1:0]     cnt_q;
  logic [D_WIDTH-1:0] seg_a;
  logic [D_WIDTH-1:0] seg_b;
  logic [D_WIDTH-1:0] seg_s;
  logic              seg_co;
  logic [W-1:0]      b_in;
  logic              c_in;

`ifdef SEGMENTED_ADDER_SEQ_SUB_EN
  // Subtract as a + ~b + 1, so the carry-out is the not-borrow.
  assign b_in = sub_i ? ~in_b_i : in_b_i;
  assign c_in = sub_i ? 1'b1 : in_c_i;
`else
  assign b_in = in_b_i;
  assign c_in = in_c_i;
`endif

  assign seg_a = a_q[int'(cnt_q)*D_WIDTH +: D_WIDTH];
  assign seg_b = b_q[int'(cnt_q)*D_WIDTH +: D_WIDTH];

  segmented_adder_seq_cla #(
    .D_WIDTH(D_WIDTH)
  ) u_cla (
    .a (seg_a),
    .b (seg_b),
    .ci(cy_q),
    .s (seg_s),
    .co(seg_co)
  );

  assign in_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cy_q        <= 1'b0;
      cnt_q       <= '0;
      out_s_o     <= '0;
      out_c_o     <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_q     <= in_a_i;
            b_q     <= b_in;
            cy_q    <= c_in;
            cnt_q   <= '0;
            out_s_o <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          out_s_o[int'(cnt_q)*D_WIDTH +: D_WIDTH] <= seg_s;
          cy_q  <= seg_co;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            out_c_o     <= seg_co;
            out_valid_o <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_segmented_adder_seq.sv
// Bench for segmented_adder_seq: vector table, random ops, scoreboard,
// back-pressure, mid-op reset, input isolation and an N_SEG=1 instance.
module tb_segmented_adder_seq;
  localparam int D = 16;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_c = 1'b0;
  logic        sub = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_s;
  logic        out_c;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  logic [7:0]  a1 = '0;
  logic [7:0]  b1 = '0;
  logic        c1 = 1'b0;
  logic        v1 = 1'b0;
  logic        r1;
  logic [7:0]  s1;
  logic        co1;
  logic        ov1;
  logic        busy1;

  int tests = 0;
  int failed = 0;
  logic [64:0] sb[$];

  always #5 clk = ~clk;

  segmented_adder_seq #(.D_WIDTH(D), .N_SEG(N)) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .in_a_i(in_a),
    .in_b_i(in_b),
    .in_c_i(in_c),
`ifdef SEGMENTED_ADDER_SEQ_SUB_EN
    .sub_i(sub),
`endif
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .out_s_o(out_s),
    .out_c_o(out_c),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .busy_o(busy)
  );

  segmented_adder_seq #(.D_WIDTH(8), .N_SEG(1)) dut1 (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .in_a_i(a1),
    .in_b_i(b1),
    .in_c_i(c1),
`ifdef SEGMENTED_ADDER_SEQ_SUB_EN
    .sub_i(1'b0),
`endif
    .in_valid_i(v1),
    .in_ready_o(r1),
    .out_s_o(s1),
    .out_c_o(co1),
    .out_valid_o(ov1),
    .out_ready_i(1'b1),
    .busy_o(busy1)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic [63:0] s;
    logic        co;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic [63:0] es,
                        input logic ec, input bit scramble);
    int lat;
    bit got;
    logic [64:0] e;
    @(posedge clk); #1;
    chk("ready_before_op", 64'(in_ready), 64'd1);
    in_a = a;
    in_b = b;
    in_c = c;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back({ec, es});
    #1 in_valid = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      if (scramble) begin
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
        in_c = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (out_valid) got = 1;
    end
    chk("latency", 64'(lat), 64'(N));
    e = sb.pop_front();
    if (got) begin
      chk("sum", out_s, e[63:0]);
      chk("carry", 64'(out_c), 64'(e[64]));
    end
    @(posedge clk); #1;
    chk("valid_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic [64:0] m;
    logic [63:0] hs;
    logic        hc;
    int          hi;
    int          lat;

    vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
    vt[1] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
              64'h0000_0000_0001_0000, 1'b0};
    vt[2] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
              64'h2222_2222_2222_2211, 1'b0};
    vt[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
              64'h0, 1'b1};
    vt[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vt[5] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
    vt[6] = '{64'h0000_FFFF_0000_FFFF, 64'h1, 1'b1,
              64'h0000_FFFF_0001_0001, 1'b0};

    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_s", out_s, 64'h0);
    chk("rst_c", 64'(out_c), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 7; i++)
      run_op(vt[i].a, vt[i].b, vt[i].c, vt[i].s, vt[i].co, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      m  = {1'b0, ra} + {1'b0, rb} + 65'(rc);
      run_op(ra, rb, rc, m[63:0], m[64], 1'b0);
    end

    // operands scrambled every CALC cycle
    run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1,
           64'h0, 1'b1, 1'b1);
    chk("idle_hold_s", out_s, 64'h0);
    chk("idle_hold_c", 64'(out_c), 64'd1);

    // back-pressure
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_a = 64'h0000_0000_0000_FFFF;
    in_b = 64'h1;
    in_c = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'(N));
    hs = out_s;
    hc = out_c;
    chk("bp_sum", hs, 64'h0000_0000_0001_0000);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_a = 64'h5;
        in_b = 64'h5;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (!out_valid || out_s !== hs || out_c !== hc || in_ready) hi++;
    end
    in_valid = 1'b0;
    chk("bp_hold_bad_cycles", 64'(hi), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    chk("bp_idle_busy", 64'(busy), 64'd0);
    chk("bp_idle_s", out_s, hs);

    // reset during segment 2
    @(posedge clk); #1;
    in_a = 64'hFFFF_FFFF_FFFF_FFFF;
    in_b = 64'h1;
    in_c = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("ar_s", out_s, 64'h0);
    chk("ar_c", 64'(out_c), 64'd0);
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    #7 rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) hi++;
    end
    chk("ar_no_output", 64'(hi), 64'd0);
    run_op(64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0);

`ifdef SEGMENTED_ADDER_SEQ_SUB_EN
    sub = 1'b1;
    run_op(64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op(64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0);
    sub = 1'b0;
`endif

    // single-segment instance
    @(posedge clk); #1;
    a1 = 8'hFF;
    b1 = 8'h01;
    c1 = 1'b1;
    v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("n1_busy", 64'(busy1), 64'd1);
    @(posedge clk); #1;
    chk("n1_valid", 64'(ov1), 64'd1);
    chk("n1_sum", 64'(s1), 64'h01);
    chk("n1_carry", 64'(co1), 64'd1);
    @(posedge clk); #1;
    chk("n1_idle", 64'(r1), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
